pcileech_tlp_tx_arb: RTL

PCILEECH_TLP_TX_ARB -- requirements
Module: pcileech_tlp_tx_arb

---
 rtl/pcileech_tlp_tx_arb.sv | 100 ++++++++++
 1 files changed

// File: rtl/pcileech_tlp_tx_arb.sv
// pcileech_tlp_tx_arb: merges two AXI-Stream TLP sources onto the PCIe TX stream, one whole packet at a time.
// Arbitration is round-robin by default; define PCILEECH_TLP_ARB_PRIO_EN for strict s0 priority.
module pcileech_tlp_tx_arb #(
  parameter int PARAM_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [63:0]                s0_tdata,
  input  logic [7:0]                 s0_tkeep,
  input  logic                       s0_tlast,
  input  logic                       s0_tvalid,
  output logic                       s0_tready,
  input  logic [63:0]                s1_tdata,
  input  logic [7:0]                 s1_tkeep,
  input  logic                       s1_tlast,
  input  logic                       s1_tvalid,
  output logic                       s1_tready,
  output logic [63:0]                m_tdata,
  output logic [7:0]                 m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [1:0]                 grant,
  output logic [PARAM_CNT_WIDTH-1:0] pkt_cnt0,
  output logic [PARAM_CNT_WIDTH-1:0] pkt_cnt1
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t r_state, w_next;
  logic [1:0] r_rst_sync;
  logic [63:0] r_m_tdata;
  logic [7:0] r_m_tkeep;
  logic r_m_tlast, r_m_tvalid;
  logic [PARAM_CNT_WIDTH-1:0] r_cnt0, r_cnt1;
  logic w_ready, w_acc0, w_acc1, w_pick1;
  assign w_ready   = ~r_m_tvalid | m_tready;
  assign s0_tready = (r_state == GRANT0) & w_ready;
  assign s1_tready = (r_state == GRANT1) & w_ready;
  assign w_acc0    = s0_tvalid & s0_tready;
  assign w_acc1    = s1_tvalid & s1_tready;
  assign grant     = {r_state == GRANT1, r_state == GRANT0};
  assign m_tdata   = r_m_tdata;
  assign m_tkeep   = r_m_tkeep;
  assign m_tlast   = r_m_tlast;
  assign m_tvalid  = r_m_tvalid;
  assign pkt_cnt0  = r_cnt0;
  assign pkt_cnt1  = r_cnt1;
`ifdef PCILEECH_TLP_ARB_PRIO_EN
  assign w_pick1 = 1'b0;
`else
  logic r_rr;
  assign w_pick1 = ~r_rr;
  // remember the last granted source (1 = s1) so the other one wins a tie; reset value gives s0 first turn
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rr <= 1'b1;
    else if (r_state == IDLE && w_next != IDLE) r_rr <= (w_next == GRANT1);
`endif
  // two-flop release of reset so the FSM only starts arbitrating on clean clock edges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rst_sync <= 2'b00;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state: pick an owner in IDLE, hold ownership until its tlast beat is accepted
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_rst_sync[1] & (s0_tvalid | s1_tvalid))
                 w_next = (s1_tvalid & (~s0_tvalid | w_pick1)) ? GRANT1 : GRANT0;
      GRANT0:  if (w_acc0 & s0_tlast) w_next = IDLE;
      GRANT1:  if (w_acc1 & s1_tlast) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // output register: load an accepted beat, drop valid once the core has taken it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_acc0 | w_acc1) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_acc1 ? s1_tdata : s0_tdata;
      r_m_tkeep  <= w_acc1 ? s1_tkeep : s0_tkeep;
      r_m_tlast  <= w_acc1 ? s1_tlast : s0_tlast;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  // per-source packet counters, free-running with wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc0 & s0_tlast) r_cnt0 <= r_cnt0 + PARAM_CNT_WIDTH'(1);
      if (w_acc1 & s1_tlast) r_cnt1 <= r_cnt1 + PARAM_CNT_WIDTH'(1);
    end
endmodule
